// File: rtl/skid_if.sv
// Valid/ready handshake bundle for the skid buffer: upstream (in_*) and downstream (out_*) sides.
interface skid_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: fully registered valid/ready stage with a main and a skid register.
module skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  skid_if.slave bus
);

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               in_xfer;
  logic               out_xfer;

  // State and all outputs are flops; reset clears held data immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  // Next state, payload moves and next-cycle output values.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    in_xfer     = bus.in_valid && in_ready_q;
    out_xfer    = out_valid_q && bus.out_ready;

    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = bus.in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = bus.in_data;
        end else if (in_xfer) begin
          skid_d  = bus.in_data;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    unique case (state_d)
      BUSY:    occ_d = OCC_W'(1);
      FULL:    occ_d = OCC_W'(2);
      default: occ_d = OCC_W'(0);
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.occupancy = occ_q;

endmodule
